mm_port_arbiter: RTL and testbench
==================================

MM_PORT_ARBITER -- requirements
Module: mm_port_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 8, Avalon-MM word address width.
REQ-002 SHALL have parameter REG_SIZE, default 32, data width.
REQ-003 SHALL have parameter RD_TIMEOUT, default 16, max cycles waited for slave readdatavalid.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports mI_address  input  ADDRESS_SIZE  requester I command address, for I in {0,1}.
REQ-007 SHALL have ports mI_writedata  input  REG_SIZE  requester I write data.
REQ-008 SHALL have ports mI_write and mI_read  input  1 each  requester I write and read strobes.
REQ-009 SHALL have ports mI_readdata  output  REG_SIZE  read data returned to requester I.
REQ-010 SHALL have ports mI_readdatavalid  output  1  requester I read data valid.
REQ-011 SHALL have ports mI_waitrequest  output  1  requester I stall; command held while high.
REQ-012 SHALL have ports slv_address, slv_writedata, slv_write, slv_read  output  ADDRESS_SIZE/REG_SIZE/1/1  command to shared register slave.
REQ-013 SHALL have ports slv_readdata, slv_readdatavalid, slv_waitrequest  input  REG_SIZE/1/1  shared slave response.
REQ-014 SHALL have port timeout_err  output  1  sticky flag, a read timed out.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RD_WAIT plus a 1-bit grant register and a 1-bit round-robin pointer rr.
REQ-016 IDLE: slv_read=slv_write=0, both mI_waitrequest=1; request_I = mI_read|mI_write.
REQ-017 IDLE, one requester pending: grant <= that requester, next state BUSY.
REQ-018 IDLE, both pending: grant <= rr, next state BUSY; rr <= ~grant when the granted command completes (REQ-022/REQ-025).
REQ-019 BUSY: slv_address/writedata/write/read SHALL equal the granted requester's inputs combinationally; granted mI_waitrequest = slv_waitrequest; other requester's waitrequest = 1.
REQ-020 Requester asserting mI_read and mI_write together: SHALL be forwarded as write only (slv_read=0); no readdatavalid returned.
REQ-021 Grant latency: command from IDLE reaches slave one cycle after request first seen; minimum two cycles per write, back-to-back.
REQ-022 BUSY, write accepted (slv_write & ~slv_waitrequest): next state IDLE.
REQ-023 BUSY, read accepted (slv_read & ~slv_waitrequest): next state RD_WAIT, timeout counter cleared to 0.
REQ-024 BUSY, granted requester drops both strobes: next state IDLE, no pointer update.
REQ-025 RD_WAIT: slv_read=slv_write=0, both waitrequest=1; on slv_readdatavalid, mG_readdata <= slv_readdata and mG_readdatavalid <= 1 for exactly one cycle (registered, 1-cycle latency); next state IDLE.
REQ-026 RD_WAIT counter increments each cycle without slv_readdatavalid; reaching RD_TIMEOUT-1 SHALL return readdata all ones with readdatavalid=1 to granted requester, set timeout_err, go IDLE.
REQ-027 slv_readdatavalid in IDLE or BUSY SHALL be dropped; no mI_readdatavalid.
REQ-028 mI_readdata SHALL hold last value when readdatavalid=0; non-granted requester never sees readdatavalid.
REQ-029 timeout_err SHALL stay 1 until reset.

Reset
REQ-030 rst_n low SHALL force state IDLE, grant=0, rr=0, counter=0, timeout_err=0, mI_readdata=0, mI_readdatavalid=0, mI_waitrequest=1, slv_read=slv_write=0.
REQ-031 Reset mid-transaction SHALL abandon it; a late slv_readdatavalid after release SHALL be dropped per REQ-027.

Verification
REQ-032 Single read: m0_read addr 0x01, slave waitrequest 0, readdatavalid 2 cycles later with 0xDEADBEEF -> m0_readdatavalid one pulse, m0_readdata=0xDEADBEEF, m1 untouched.
REQ-033 Contention: m0 and m1 both write continuously from reset -> slave sees m0, m1, m0, m1 alternating; each waitrequest low exactly on its own accepted cycle.
REQ-034 Slave stall: slv_waitrequest high 5 cycles during m1 read -> m1_waitrequest high those 5 cycles, slv_address stable, one readdatavalid afterwards.
REQ-035 Timeout: slave never returns readdatavalid on m0 read -> after 16 RD_WAIT cycles m0_readdata=0xFFFFFFFF, readdatavalid pulse, timeout_err=1 until reset.
REQ-036 Reset in RD_WAIT, slave responds 2 cycles after release -> no mI_readdatavalid, all outputs at reset values.
REQ-037 m0 read+write together, addr 0x02 -> slv_write=1, slv_read=0, no m0_readdatavalid.

Source files
------------

// File: rtl/mm_port_arbiter_if.sv
// Avalon-MM style command/response bundle used for both requester ports and the shared slave port.
// The master modport drives commands; the slave modport answers them.
interface mm_port_arbiter_if #(
    parameter int ADDRESS_SIZE = 8,
    parameter int REG_SIZE     = 32
);
    logic [ADDRESS_SIZE-1:0] address;
    logic [REG_SIZE-1:0]     writedata;
    logic                    write;
    logic                    read;
    logic [REG_SIZE-1:0]     readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, writedata, write, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, writedata, write, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/mm_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single Avalon-MM register slave,
// with a bounded wait for read data and a sticky timeout flag.
module mm_port_arbiter #(
    parameter int ADDRESS_SIZE = 8,
    parameter int REG_SIZE     = 32,
    parameter int RD_TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mm_port_arbiter_if.slave  m0,
    mm_port_arbiter_if.slave  m1,
    mm_port_arbiter_if.master slv,
    output logic              timeout_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    localparam int                CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    logic [1:0]              state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]        waitCnt_q, waitCnt_d;
    logic                    timeoutErr_q, timeoutErr_d;
    logic [REG_SIZE-1:0]     rdData0_q, rdData0_d;
    logic [REG_SIZE-1:0]     rdData1_q, rdData1_d;
    logic                    rdValid0_q, rdValid0_d;
    logic                    rdValid1_q, rdValid1_d;

    logic                    req0, req1;
    logic                    inBusy;
    logic [ADDRESS_SIZE-1:0] reqAddr;
    logic [REG_SIZE-1:0]     reqWdata;
    logic                    reqWrite;
    logic                    reqRead;
    logic [REG_SIZE-1:0]     respData;

    assign req0   = m0.read | m0.write;
    assign req1   = m1.read | m1.write;
    assign inBusy = (state_q == BUSY);

    // A requester raising read and write together is treated as a plain write.
    always_comb begin
        reqAddr  = grant_q ? m1.address   : m0.address;
        reqWdata = grant_q ? m1.writedata : m0.writedata;
        reqWrite = grant_q ? m1.write     : m0.write;
        reqRead  = (grant_q ? m1.read : m0.read) & ~reqWrite;
    end

    assign slv.address   = reqAddr;
    assign slv.writedata = reqWdata;
    assign slv.write     = inBusy & reqWrite;
    assign slv.read      = inBusy & reqRead;

    assign m0.waitrequest = (inBusy && !grant_q) ? slv.waitrequest : 1'b1;
    assign m1.waitrequest = (inBusy &&  grant_q) ? slv.waitrequest : 1'b1;

    assign m0.readdata      = rdData0_q;
    assign m0.readdatavalid = rdValid0_q;
    assign m1.readdata      = rdData1_q;
    assign m1.readdatavalid = rdValid1_q;
    assign timeout_err      = timeoutErr_q;

    // The pointer only moves once the granted command has fully completed,
    // including a read that ends by timing out.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rrPtr_d      = rrPtr_q;
        waitCnt_d    = waitCnt_q;
        timeoutErr_d = timeoutErr_q;
        rdData0_d    = rdData0_q;
        rdData1_d    = rdData1_q;
        rdValid0_d   = 1'b0;
        rdValid1_d   = 1'b0;
        respData     = '1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = (req0 && req1) ? rrPtr_q : req1;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (reqWrite && !slv.waitrequest) begin
                    rrPtr_d = ~grant_q;
                    state_d = IDLE;
                end else if (reqRead && !slv.waitrequest) begin
                    waitCnt_d = '0;
                    state_d   = RD_WAIT;
                end else if (!reqWrite && !reqRead) begin
                    state_d = IDLE;
                end
            end

            RD_WAIT: begin
                if (slv.readdatavalid || (waitCnt_q == CNT_LAST)) begin
                    if (slv.readdatavalid) begin
                        respData = slv.readdata;
                    end else begin
                        timeoutErr_d = 1'b1;
                    end
                    if (grant_q) begin
                        rdData1_d  = respData;
                        rdValid1_d = 1'b1;
                    end else begin
                        rdData0_d  = respData;
                        rdValid0_d = 1'b1;
                    end
                    rrPtr_d = ~grant_q;
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            rrPtr_q      <= 1'b0;
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
            rdData0_q    <= '0;
            rdData1_q    <= '0;
            rdValid0_q   <= 1'b0;
            rdValid1_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rrPtr_q      <= rrPtr_d;
            waitCnt_q    <= waitCnt_d;
            timeoutErr_q <= timeoutErr_d;
            rdData0_q    <= rdData0_d;
            rdData1_q    <= rdData1_d;
            rdValid0_q   <= rdValid0_d;
            rdValid1_q   <= rdValid1_d;
        end
    end

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Bench for mm_port_arbiter: directed scenarios plus randomized single transactions,
// compared against a transaction-level memory model and round-robin ordering rules.
module tb_mm_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic timeoutErr;

    int vecCount = 0;
    int errCount = 0;

    logic [DW-1:0] slaveMem [0:255];
    logic [DW-1:0] refMem   [0:255];

    always #5 clk = ~clk;

    mm_port_arbiter_if #(.ADDRESS_SIZE(AW), .REG_SIZE(DW)) m0Bus ();
    mm_port_arbiter_if #(.ADDRESS_SIZE(AW), .REG_SIZE(DW)) m1Bus ();
    mm_port_arbiter_if #(.ADDRESS_SIZE(AW), .REG_SIZE(DW)) slvBus ();

    mm_port_arbiter #(.ADDRESS_SIZE(AW), .REG_SIZE(DW), .RD_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0Bus),
        .m1          (m1Bus),
        .slv         (slvBus),
        .timeout_err (timeoutErr)
    );

    // Packed view: {wait0, wait1, valid0, valid1, slvRead, slvWrite}
    function automatic logic [5:0] busSnap();
        return {m0Bus.waitrequest, m1Bus.waitrequest, m0Bus.readdatavalid,
                m1Bus.readdatavalid, slvBus.read, slvBus.write};
    endfunction

    function automatic logic [DW-1:0] readData(input int r);
        return (r == 0) ? m0Bus.readdata : m1Bus.readdata;
    endfunction

    task automatic driveReq(input int r, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (r == 0) begin
            m0Bus.read = rd; m0Bus.write = wr; m0Bus.address = addr; m0Bus.writedata = data;
        end else begin
            m1Bus.read = rd; m1Bus.write = wr; m1Bus.address = addr; m1Bus.writedata = data;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        driveReq(0, 1'b0, 1'b0, '0, '0);
        driveReq(1, 1'b0, 1'b0, '0, '0);
        slvBus.waitrequest = 1'b0;
        slvBus.readdatavalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One command from requester r; entered and left at posedge+1 with the arbiter idle.
    task automatic runTxn(input int r, input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int stall, input int lat, input logic noise);
        logic          isRead;
        logic [1:0]    strobe;
        logic [5:0]    busyExp, grantExp, doneExp;
        logic [AW-1:0] slvAddr;
        logic [DW-1:0] expData;
        isRead   = rd & ~wr;
        strobe   = isRead ? 2'b10 : 2'b01;
        busyExp  = {4'b1100, strobe};
        grantExp = {(r != 0), (r != 1), 2'b00, strobe};
        doneExp  = {2'b11, (r == 0), (r == 1), 2'b00};

        driveReq(r, rd, wr, addr, wdata);
        slvBus.waitrequest   = (stall > 0);
        slvBus.readdatavalid = noise;
        slvBus.readdata      = $urandom;
        @(negedge clk);
        vecCount++;
        if (busSnap() !== 6'b110000) begin
            errCount++; $display("[TB] FAIL grant_latency: got %b expected %b", busSnap(), 6'b110000);
        end
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            vecCount++;
            if ({busSnap(), slvBus.address} !== {busyExp, addr}) begin
                errCount++; $display("[TB] FAIL stall_hold: got %b/%h expected %b/%h", busSnap(), slvBus.address, busyExp, addr);
            end
            @(posedge clk); #1;
        end
        slvBus.waitrequest = 1'b0;
        @(negedge clk);
        vecCount++;
        if ({busSnap(), slvBus.address} !== {grantExp, addr}) begin
            errCount++; $display("[TB] FAIL grant_bus: got %b/%h expected %b/%h", busSnap(), slvBus.address, grantExp, addr);
        end
        if (wr) begin
            vecCount++;
            if (slvBus.writedata !== wdata) begin
                errCount++; $display("[TB] FAIL write_data: got %h expected %h", slvBus.writedata, wdata);
            end
            slaveMem[slvBus.address] = slvBus.writedata;
            refMem[addr] = wdata;
        end
        slvAddr = slvBus.address;
        expData = refMem[addr];
        @(posedge clk); #1;
        driveReq(r, 1'b0, 1'b0, AW'($urandom), $urandom);
        slvBus.readdatavalid = 1'b0;
        if (isRead) begin
            for (int j = 0; j < lat; j++) begin
                @(negedge clk);
                vecCount++;
                if (busSnap() !== 6'b110000) begin
                    errCount++; $display("[TB] FAIL rdwait_hold: got %b expected %b", busSnap(), 6'b110000);
                end
                @(posedge clk); #1;
            end
            slvBus.readdatavalid = 1'b1;
            slvBus.readdata      = slaveMem[slvAddr];
            @(negedge clk);
            vecCount++;
            if (busSnap() !== 6'b110000) begin
                errCount++; $display("[TB] FAIL rdvalid_latency: got %b expected %b", busSnap(), 6'b110000);
            end
            @(posedge clk); #1;
            slvBus.readdatavalid = 1'b0;
            slvBus.readdata      = $urandom;
            @(negedge clk);
            vecCount++;
            if ({busSnap(), readData(r)} !== {doneExp, expData}) begin
                errCount++; $display("[TB] FAIL read_return: got %b/%h expected %b/%h", busSnap(), readData(r), doneExp, expData);
            end
            @(posedge clk); #1;
            @(negedge clk);
            vecCount++;
            if ({busSnap(), readData(r)} !== {6'b110000, expData}) begin
                errCount++; $display("[TB] FAIL read_hold: got %b/%h expected %b/%h", busSnap(), readData(r), 6'b110000, expData);
            end
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            vecCount++;
            if (busSnap() !== 6'b110000) begin
                errCount++; $display("[TB] FAIL write_done: got %b expected %b", busSnap(), 6'b110000);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        slvBus.waitrequest = 1'b0;
        slvBus.readdatavalid = 1'b0;
        slvBus.readdata = '0;
        driveReq(0, 1'b0, 1'b1, 8'h10, 32'h1234_5678);
        driveReq(1, 1'b1, 1'b0, 8'h11, 32'h0);
        @(negedge clk);
        vecCount++;
        if ({busSnap(), m0Bus.readdata, m1Bus.readdata, timeoutErr} !== {6'b110000, 32'h0, 32'h0, 1'b0}) begin
            errCount++; $display("[TB] FAIL reset_values: got %b/%h/%h/%b expected 110000/0/0/0",
                                 busSnap(), m0Bus.readdata, m1Bus.readdata, timeoutErr);
        end
        driveReq(0, 1'b0, 1'b0, '0, '0);
        driveReq(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        slaveMem[1] = 32'hDEAD_BEEF;
        refMem[1]   = 32'hDEAD_BEEF;
        runTxn(0, 1'b1, 1'b0, 8'h01, 32'h0, 0, 2, 1'b0);
        vecCount++;
        if (m1Bus.readdata !== 32'h0) begin
            errCount++; $display("[TB] FAIL single_read_m1: got %h expected %h", m1Bus.readdata, 32'h0);
        end
    endtask

    task automatic test_stall();
        runTxn(1, 1'b1, 1'b0, AW'($urandom), 32'h0, 5, 2, 1'b0);
    endtask

    task automatic test_dual_strobe();
        runTxn(0, 1'b1, 1'b1, 8'h02, $urandom, 0, 0, 1'b0);
    endtask

    task automatic test_contention();
        logic [AW-1:0] addr [2];
        logic [DW-1:0] data [2];
        logic [5:0]    expSnap;
        int            accepted, cycles, owner;
        doReset();
        for (int k = 0; k < 2; k++) begin
            addr[k] = {AW'($urandom) >> 1, k[0]};
            data[k] = $urandom;
            driveReq(k, 1'b0, 1'b1, addr[k], data[k]);
        end
        accepted = 0;
        cycles   = 0;
        while (accepted < 12 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            owner = accepted % 2;
            if (slvBus.write) begin
                expSnap = (owner == 0) ? 6'b010001 : 6'b100001;
                vecCount++;
                if ({busSnap(), slvBus.address, slvBus.writedata} !== {expSnap, addr[owner], data[owner]}) begin
                    errCount++; $display("[TB] FAIL contention_order: got %b/%h/%h expected %b/%h/%h", busSnap(),
                                         slvBus.address, slvBus.writedata, expSnap, addr[owner], data[owner]);
                end
                slaveMem[slvBus.address] = slvBus.writedata;
                refMem[addr[owner]] = data[owner];
                accepted++;
                @(posedge clk); #1;
                addr[owner] = {AW'($urandom) >> 1, owner[0]};
                data[owner] = $urandom;
                driveReq(owner, 1'b0, 1'b1, addr[owner], data[owner]);
            end else begin
                vecCount++;
                if (busSnap() !== 6'b110000) begin
                    errCount++; $display("[TB] FAIL contention_gap: got %b expected %b", busSnap(), 6'b110000);
                end
                @(posedge clk); #1;
            end
        end
        vecCount++;
        if (cycles !== 24) begin
            errCount++; $display("[TB] FAIL contention_rate: got %0d cycles expected %0d", cycles, 24);
        end
        driveReq(0, 1'b0, 1'b0, '0, '0);
        driveReq(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int r, op;
        for (int n = 0; n < 24; n++) begin
            r  = int'($urandom_range(1, 0));
            op = int'($urandom_range(2, 0));
            runTxn(r, (op != 1), (op != 0), AW'($urandom_range(15, 0)), $urandom,
                   int'($urandom_range(3, 0)), int'($urandom_range(5, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_timeout();
        int   waitCycles;
        logic seen;
        driveReq(0, 1'b1, 1'b0, AW'($urandom), '0);
        slvBus.waitrequest = 1'b0;
        slvBus.readdatavalid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vecCount++;
        if (busSnap() !== 6'b010010) begin
            errCount++; $display("[TB] FAIL timeout_accept: got %b expected %b", busSnap(), 6'b010010);
        end
        @(posedge clk); #1;
        driveReq(0, 1'b0, 1'b0, '0, '0);
        waitCycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * TMO && !seen; i++) begin
            @(negedge clk);
            if (m0Bus.readdatavalid === 1'b1) seen = 1'b1;
            else waitCycles++;
        end
        vecCount++;
        if (waitCycles !== TMO) begin
            errCount++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", waitCycles, TMO);
        end
        vecCount++;
        if ({m0Bus.readdata, timeoutErr, m1Bus.readdatavalid} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
            errCount++; $display("[TB] FAIL timeout_response: got %h/%b/%b expected ffffffff/1/0",
                                 m0Bus.readdata, timeoutErr, m1Bus.readdatavalid);
        end
        @(posedge clk); #1;
        runTxn(1, 1'b0, 1'b1, AW'($urandom), $urandom, 0, 0, 1'b0);
        vecCount++;
        if (timeoutErr !== 1'b1) begin
            errCount++; $display("[TB] FAIL timeout_sticky: got %b expected %b", timeoutErr, 1'b1);
        end
    endtask

    task automatic test_reset_in_rdwait();
        driveReq(1, 1'b1, 1'b0, AW'($urandom), '0);
        slvBus.waitrequest = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vecCount++;
        if (busSnap() !== 6'b100010) begin
            errCount++; $display("[TB] FAIL rst_rdwait_accept: got %b expected %b", busSnap(), 6'b100010);
        end
        @(posedge clk); #1;
        driveReq(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        vecCount++;
        if ({busSnap(), m0Bus.readdata, m1Bus.readdata, timeoutErr} !== {6'b110000, 32'h0, 32'h0, 1'b0}) begin
            errCount++; $display("[TB] FAIL rst_rdwait_values: got %b/%h/%h/%b expected 110000/0/0/0",
                                 busSnap(), m0Bus.readdata, m1Bus.readdata, timeoutErr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        slvBus.readdatavalid = 1'b1;
        slvBus.readdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        slvBus.readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecCount++;
            if ({busSnap(), m0Bus.readdata, m1Bus.readdata, timeoutErr} !== {6'b110000, 32'h0, 32'h0, 1'b0}) begin
                errCount++; $display("[TB] FAIL late_valid_drop: got %b/%h/%h/%b expected 110000/0/0/0",
                                     busSnap(), m0Bus.readdata, m1Bus.readdata, timeoutErr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            slaveMem[i] = $urandom;
            refMem[i]   = slaveMem[i];
        end
        test_reset();
        test_single_read();
        test_stall();
        test_dual_strobe();
        test_contention();
        test_random();
        test_timeout();
        test_reset_in_rdwait();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
